// File: rtl/serial_and_unit.sv
// serial_and_unit: collects two LSB-first serial operands one bit pair per
// accepted beat and presents their bitwise AND (plus its AND-reduction) as a
// held result word. A word is gathered in COLLECT and presented in HOLD.
//
// Handshake: a beat transfers on a rising edge with in_valid=1 and in_ready=1,
// and a result transfers on a rising edge with out_valid=1 and out_ready=1.
// Neither valid depends combinationally on the matching ready. in_ready and
// out_valid decode straight from the state register.
module serial_and_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             a_bit,
   input  logic             b_bit,
   input  logic             in_first,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_word,
   output logic             out_all,
   output logic             resync_err
);

   // The bit counter needs at least one bit, even when WIDTH is 1.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] col_q;
   logic [WIDTH-1:0] word_q;
   logic             all_q;
   logic             resync_q;

   logic             accept;
   logic             resync;
   logic             done;
   logic [CW-1:0]    idx;
   logic [WIDTH-1:0] word_nx;

   assign in_ready   = (state_q == COLLECT);
   assign out_valid  = (state_q == HOLD);
   assign out_word   = word_q;
   assign out_all    = all_q;
   assign resync_err = resync_q;

   assign accept = in_valid & in_ready;

   // Beat datapath: pick the bit slot, handle resync, and build the next word.
   always_comb begin
      resync    = 1'b0;
      idx       = bit_cnt_q;
      word_nx   = col_q;
      done      = 1'b0;
      bit_cnt_d = bit_cnt_q;
      if (accept) begin
         // A first-marker in the middle of a word restarts at bit 0.
         if (in_first && (bit_cnt_q != '0)) begin
            resync = 1'b1;
            idx    = '0;
         end
         // Bit 0 of any word starts from a clean register.
         if (idx == '0) begin
            word_nx = '0;
         end
         word_nx[idx] = a_bit & b_bit;
         done         = (idx == LAST_IDX);
         bit_cnt_d    = done ? '0 : (idx + CW'(1));
      end
   end

   // Next-state logic: COLLECT until the last beat lands, HOLD until consumed.
   always_comb begin
      state_d = state_q;
      case (state_q)
         COLLECT: if (done)      state_d = HOLD;
         HOLD:    if (out_ready) state_d = COLLECT;
         default:                state_d = COLLECT;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= COLLECT;
      end else begin
         state_q <= state_d;
      end
   end

   // Collect register, bit counter and resync pulse; only accepted beats move them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_q <= '0;
         col_q     <= '0;
         resync_q  <= 1'b0;
      end else begin
         resync_q <= resync;
         if (accept) begin
            bit_cnt_q <= bit_cnt_d;
            col_q     <= word_nx;
         end
      end
   end

   // Result registers load only on the completing beat and otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         all_q  <= 1'b0;
      end else if (done) begin
         word_q <= word_nx;
         all_q  <= &word_nx;
      end
   end

endmodule

// File: tb/tb_serial_and_unit.sv
// tb_serial_and_unit: drives serial operand words into serial_and_unit and
// compares each consumed result against an expected queue filled at drive time.
module tb_serial_and_unit;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic         a_bit;
   logic         b_bit;
   logic         in_first;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_word;
   logic         out_all;
   logic         resync_err;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [W-1:0] exp_q[$];
   logic         exp_all_q[$];

   serial_and_unit #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a_bit      (a_bit),
      .b_bit      (b_bit),
      .in_first   (in_first),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_word   (out_word),
      .out_all    (out_all),
      .resync_err (resync_err)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: pop one expectation per consumed result.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'(out_word), 32'hFFFF_FFFF);
         end else begin
            logic [W-1:0] e;
            logic         ea;
            e  = exp_q.pop_front();
            ea = exp_all_q.pop_front();
            chk("sb_word", 32'(out_word), 32'(e));
            chk("sb_all", 32'(out_all), 32'(ea));
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("ready_timeout", 0, 1);
   endtask

   task automatic beat(input logic a, input logic b, input logic first);
      wait_ready();
      in_valid = 1'b1;
      a_bit    = a;
      b_bit    = b;
      in_first = first;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_first = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b, input bit use_first,
                            input int idle_after, input int idle_n, output int done_cyc);
      logic [W-1:0] e;
      e = a & b;
      exp_q.push_back(e);
      exp_all_q.push_back(&e);
      for (int i = 0; i < W; i++) begin
         beat(a[i], b[i], use_first && (i == 0));
         if (i < W - 1) chk("no_early_valid", 32'(out_valid), 0);
         if (i == idle_after) begin
            repeat (idle_n) begin
               @(posedge clk); #1;
            end
         end
      end
      done_cyc = cyc;
      chk("latency_valid", 32'(out_valid), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int dc;
      int prev;
      logic [W-1:0] ra, rb;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a_bit     = 1'b0;
      b_bit     = 1'b0;
      in_first  = 1'b0;
      out_ready = 1'b1;

      // Reset values before any clock edge.
      #2;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_word", 32'(out_word), 0);
      chk("rst_out_all", 32'(out_all), 0);
      chk("rst_resync", 32'(resync_err), 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Contiguous word, partial AND.
      send_word(8'hFF, 8'h0F, 1'b1, -1, 0, dc);
      chk("w1_word", 32'(out_word), 32'h0F);
      chk("w1_all", 32'(out_all), 0);
      @(posedge clk); #1;

      // Idle cycles inside a word.
      send_word(8'hFF, 8'hFF, 1'b1, 2, 2, dc);
      chk("w2_all", 32'(out_all), 1);
      @(posedge clk); #1;

      // Back-pressure: held result ignores new beats.
      out_ready = 1'b0;
      send_word(8'h5A, 8'h3C, 1'b1, -1, 0, dc);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         a_bit    = 1'($urandom_range(1, 0));
         b_bit    = 1'($urandom_range(1, 0));
         in_first = 1'($urandom_range(1, 0));
         @(posedge clk); #1;
         chk("hold_in_ready", 32'(in_ready), 0);
         chk("hold_out_valid", 32'(out_valid), 1);
         chk("hold_word", 32'(out_word), 32'h18);
      end
      in_valid  = 1'b0;
      in_first  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_out_valid", 32'(out_valid), 0);
      chk("release_in_ready", 32'(in_ready), 1);

      // Resync: 3 beats, then a new first beat restarting the word.
      exp_q.push_back(8'hAA);
      exp_all_q.push_back(1'b0);
      beat(1'b1, 1'b1, 1'b1);
      chk("first_no_resync", 32'(resync_err), 0);
      beat(1'b1, 1'b1, 1'b0);
      beat(1'b1, 1'b1, 1'b0);
      beat(1'b0, 1'b1, 1'b1);
      chk("resync_pulse", 32'(resync_err), 1);
      for (int i = 1; i < W; i++) begin
         logic [W-1:0] av;
         av = 8'hAA;
         beat(av[i], 1'b1, 1'b0);
         if (i == 1) chk("resync_one_cycle", 32'(resync_err), 0);
         if (i < W - 1) chk("resync_no_early", 32'(out_valid), 0);
      end
      chk("resync_valid", 32'(out_valid), 1);
      chk("resync_word", 32'(out_word), 32'hAA);
      @(posedge clk); #1;

      // Reset mid-word, asserted between edges.
      for (int i = 0; i < 4; i++) beat(1'b1, 1'b1, i == 0);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_out_word", 32'(out_word), 0);
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_in_ready", 32'(in_ready), 1);
      chk("mid_rst_out_all", 32'(out_all), 0);
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      send_word(8'h81, 8'h81, 1'b0, -1, 0, dc);
      chk("post_rst_word", 32'(out_word), 32'h81);
      @(posedge clk); #1;

      // Back-to-back random words with out_ready tied high.
      prev = 0;
      for (int k = 0; k < 6; k++) begin
         ra = W'($urandom_range(255, 0));
         rb = W'($urandom_range(255, 0));
         send_word(ra, rb, 1'b1, -1, 0, dc);
         if (k > 0) chk("b2b_gap", 32'(dc - prev), 9);
         prev = dc;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
